// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, the reset PC (also used by the PC register),
// the NOP encoding and the {pc, instr} word carried through the fetch stage.
package cpu_pkg;

  typedef enum logic [1:0] {
    REQ,    // request issued on imem, waiting for accept
    WAIT,   // one request in flight
    HOLD,   // response parked in the skid buffer, ID stalled
    DRAIN   // in-flight response is stale (redirected) and will be dropped
  } fetch_state_t;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  // 32-bit wrapping increment: 0xFFFF_FFFC + 4 = 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bundle.
//   imem_req/imem_addr    : fetch request (master -> slave)
//   imem_ready            : slave accepts when req && ready
//   imem_rvalid/imem_rdata: one-cycle response pulse per accepted request
interface inst_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} buffer that catches a fetch response while ID is stalled.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : capture word_i and mark full
//   unload_i      : mark empty (word_o is consumed in the same cycle)
//   clear_i       : discard contents; wins over load/unload
//   word_o,full_o : stored word and occupancy flag
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  fetch_word_t word_i,
  output fetch_word_t word_o,
  output logic        full_o
);

  logic        full_d, full_q;
  fetch_word_t word_d, word_q;

  always_comb begin
    full_d = full_q;
    word_d = word_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
      word_d = word_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      word_q <= '0;
    end else begin
      full_q <= full_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_q;
  assign full_o = full_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: issues one imem request at a time from pc_value, advances the PC on accept,
// and delivers responses into the IF/ID register with a one-entry skid buffer for ID stalls.
// Redirects flush IF/ID and the skid buffer and drop any stale in-flight response.
//   clock, reset          : clock, async active-low reset
//   pc_value/pc_enable/pc_next : PC register read and write-back
//   redirect_valid/target : taken branch/jump from ID
//   id_stall              : ID cannot take a new IF/ID word
//   imem                  : instruction-memory master port
//   ifid_*                : IF/ID pipeline register outputs
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               pc_value,
  output logic                      pc_enable,
  output logic [31:0]               pc_next,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_target,
  input  logic                      id_stall,
  inst_fetch_unit_if.master         imem,
  output logic                      ifid_valid,
  output logic [31:0]               ifid_pc,
  output logic [31:0]               ifid_pc_plus4,
  output logic [31:0]               ifid_instr
);

  fetch_state_t state_d, state_q;
  logic         out_valid_d, out_valid_q;
  fetch_word_t  out_word_d, out_word_q;
  logic [31:0]  inflight_pc_d, inflight_pc_q;

  logic         accept;
  logic         out_free;
  logic         skid_load, skid_unload, skid_clear, skid_full;
  fetch_word_t  skid_word, resp_word;

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_value;
  assign accept         = (state_q == REQ) && imem.imem_ready;
  // The IF/ID slot can take a word when empty or when ID is consuming it this cycle.
  assign out_free       = !out_valid_q || !id_stall;
  assign resp_word      = '{pc: inflight_pc_q, instr: imem.imem_rdata};

  assign pc_enable = accept || redirect_valid;
  assign pc_next   = redirect_valid ? redirect_target : pc_plus4(pc_value);

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    out_word_d    = out_word_q;
    inflight_pc_d = inflight_pc_q;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_clear    = 1'b0;

    // Word consumed by ID and nothing replaces it: slot becomes a bubble.
    if (out_free) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      REQ: begin
        if (accept) begin
          state_d       = WAIT;
          inflight_pc_d = pc_value;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (out_free) begin
            out_valid_d = 1'b1;
            out_word_d  = resp_word;
            state_d     = REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (!id_stall && skid_full) begin
          out_valid_d = 1'b1;
          out_word_d  = skid_word;
          skid_unload = 1'b1;
          state_d     = REQ;
        end
      end
      DRAIN: begin
        if (imem.imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    if (redirect_valid) begin
      out_valid_d = 1'b0;
      out_word_d  = out_word_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b1;
      // A response still owed by memory must be swallowed before fetching the target.
      if ((((state_q == WAIT) || (state_q == DRAIN)) && !imem.imem_rvalid) || accept) begin
        state_d = DRAIN;
      end else begin
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= REQ;
      out_valid_q   <= 1'b0;
      out_word_q    <= '{pc: 32'h0, instr: NOP_INSTR};
      inflight_pc_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_word_q    <= out_word_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk_i    (clock),
    .rst_ni   (reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .word_i   (resp_word),
    .word_o   (skid_word),
    .full_o   (skid_full)
  );

  assign ifid_valid    = out_valid_q;
  assign ifid_pc       = out_word_q.pc;
  assign ifid_pc_plus4 = pc_plus4(out_word_q.pc);
  assign ifid_instr    = out_valid_q ? out_word_q.instr : NOP_INSTR;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios then randomized traffic, all checked against
// a transaction-level model (in-flight request, IF/ID slot, skid queue) and a latency memory.
module tb_inst_fetch_unit;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_value = RESET_PC;
  logic        pc_enable;
  logic [31:0] pc_next;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        id_stall = 1'b0;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;

  inst_fetch_unit_if imem_bus ();

  inst_fetch_unit #(.NOP_INSTR(INSTR_NOP)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc_value        (pc_value),
    .pc_enable       (pc_enable),
    .pc_next         (pc_next),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_stall        (id_stall),
    .imem            (imem_bus),
    .ifid_valid      (ifid_valid),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_instr      (ifid_instr)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [31:0] pc_reg;
  bit          m_inflight, m_stale;
  logic [31:0] m_inflight_pc;
  bit          m_out_valid;
  logic [31:0] m_out_pc, m_out_instr;
  fetch_word_t m_skid_q[$];

  // Memory model
  bit          mem_busy;
  int          mem_cnt;
  int          mem_k = 1;
  logic [31:0] mem_data;
  bit          mem_force = 1'b0;
  logic [31:0] mem_force_data = '0;

  // Outputs sampled in the last step
  logic        s_req, s_pc_en, s_valid;
  logic [31:0] s_addr, s_pc_next, s_pc, s_plus4, s_instr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pc_reg      = RESET_PC;
    m_inflight  = 1'b0;
    m_stale     = 1'b0;
    m_out_valid = 1'b0;
    m_out_pc    = '0;
    m_out_instr = INSTR_NOP;
    m_skid_q.delete();
    mem_busy    = 1'b0;
  endtask

  task automatic drive_idle();
    imem_bus.imem_ready  = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    id_stall             = 1'b0;
    redirect_valid       = 1'b0;
    redirect_target      = '0;
  endtask

  // Pulse reset between clock edges and check the asynchronous reset values.
  task automatic do_reset();
    @(negedge clock);
    drive_idle();
    reset = 1'b0;
    #1;
    check_eq("rst_ifid_valid", ifid_valid, 0);
    check_eq("rst_ifid_pc", ifid_pc, 32'h0);
    check_eq("rst_ifid_pc_plus4", ifid_pc_plus4, 32'h4);
    check_eq("rst_ifid_instr", ifid_instr, INSTR_NOP);
    check_eq("rst_imem_req", imem_bus.imem_req, 1);
    #2;
    reset = 1'b1;
    model_reset();
    pc_value = RESET_PC;
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input bit ready, input bit stall, input bit redir, input logic [31:0] tgt);
    bit          can_issue, accept, rvalid, out_free, have_w;
    logic [31:0] exp_next, rdata;
    fetch_word_t w;
    @(negedge clock);
    pc_value             = pc_reg;
    rvalid               = mem_busy && (mem_cnt == 1);
    rdata                = rvalid ? mem_data : $urandom;
    imem_bus.imem_ready  = ready;
    imem_bus.imem_rvalid = rvalid;
    imem_bus.imem_rdata  = rdata;
    id_stall             = stall;
    redirect_valid       = redir;
    redirect_target      = tgt;
    #1;
    s_req = imem_bus.imem_req; s_addr = imem_bus.imem_addr;
    s_pc_en = pc_enable; s_pc_next = pc_next;
    s_valid = ifid_valid; s_pc = ifid_pc; s_plus4 = ifid_pc_plus4; s_instr = ifid_instr;

    can_issue = !m_inflight && (m_skid_q.size() == 0);
    accept    = can_issue && ready;
    exp_next  = redir ? tgt : pc_reg + 32'd4;
    check_eq("imem_req", s_req, can_issue);
    if (can_issue) check_eq("imem_addr", s_addr, pc_reg);
    check_eq("pc_enable", s_pc_en, accept || redir);
    check_eq("pc_next", s_pc_next, exp_next);
    check_eq("ifid_valid", s_valid, m_out_valid);
    if (m_out_valid) begin
      check_eq("ifid_pc", s_pc, m_out_pc);
      check_eq("ifid_pc_plus4", s_plus4, m_out_pc + 32'd4);
      check_eq("ifid_instr", s_instr, m_out_instr);
    end else begin
      check_eq("ifid_instr_nop", s_instr, INSTR_NOP);
    end
    if (rvalid) check_eq("rvalid_while_in_flight", m_inflight, 1);

    @(posedge clock);
    if (mem_busy) begin
      if (mem_cnt == 1) mem_busy = 1'b0;
      else mem_cnt--;
    end
    if (accept) begin
      mem_busy = 1'b1;
      mem_cnt  = mem_k;
      mem_data = mem_force ? mem_force_data : $urandom;
    end

    out_free = !m_out_valid || !stall;
    if (redir) begin
      m_out_valid = 1'b0;
      m_skid_q.delete();
      if (rvalid) m_inflight = 1'b0;
      else if (accept || m_inflight) begin
        m_inflight = 1'b1;
        m_stale    = 1'b1;
      end
    end else begin
      have_w = 1'b0;
      if (rvalid) begin
        m_inflight = 1'b0;
        if (!m_stale) begin
          have_w = 1'b1;
          w      = '{pc: m_inflight_pc, instr: rdata};
        end
      end
      if (m_skid_q.size() != 0 && !stall) begin
        w           = m_skid_q.pop_front();
        m_out_valid = 1'b1;
        m_out_pc    = w.pc;
        m_out_instr = w.instr;
      end else if (have_w) begin
        if (out_free) begin
          m_out_valid = 1'b1;
          m_out_pc    = w.pc;
          m_out_instr = w.instr;
        end else begin
          m_skid_q.push_back(w);
        end
      end else if (out_free) begin
        m_out_valid = 1'b0;
      end
      if (accept) begin
        m_inflight    = 1'b1;
        m_stale       = 1'b0;
        m_inflight_pc = pc_reg;
      end
    end
    if (redir || accept) pc_reg = exp_next;
  endtask

  logic [31:0] pa, pb, tgt;
  bit          rr, rs, rd;

  initial begin
    drive_idle();
    model_reset();
    repeat (3) @(negedge clock);
    do_reset();

    // Reset release, ready=1, k=1
    mem_k = 1;
    step(1, 0, 0, 0);
    check_eq("c0_imem_addr", s_addr, 32'h0040_0000);
    check_eq("c0_pc_next", s_pc_next, 32'h0040_0004);
    check_eq("c0_pc_enable", s_pc_en, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("c2_ifid_valid", s_valid, 1);
    check_eq("c2_ifid_pc", s_pc, 32'h0040_0000);

    // Memory not ready for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check_eq("nrdy_req", s_req, 1);
      check_eq("nrdy_addr", s_addr, 32'h0040_0004);
      check_eq("nrdy_pc_enable", s_pc_en, 0);
    end
    step(1, 0, 0, 0);
    check_eq("nrdy_accept_pc_enable", s_pc_en, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // ID stall across two responses
    pa = pc_reg;
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    pb = pc_reg;
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 0);
      check_eq("stall_no_third_req", s_req, 0);
      check_eq("stall_hold_pc", s_pc, pa);
    end
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check_eq("stall_release_valid", s_valid, 1);
    check_eq("stall_release_pc", s_pc, pb);
    step(0, 0, 0, 0);

    // Redirect while waiting on a slow response
    mem_k = 3; mem_force = 1'b1; mem_force_data = 32'hDEAD_BEEF;
    step(1, 0, 0, 0);
    mem_force = 1'b0;
    step(0, 0, 1, 32'h0040_0100);
    check_eq("redir_wait_pc_next", s_pc_next, 32'h0040_0100);
    check_eq("redir_wait_pc_enable", s_pc_en, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      check_eq("redir_no_deadbeef", (s_instr == 32'hDEAD_BEEF), 0);
      if (i == 0) check_eq("redir_drain_no_req", s_req, 0);
      if (i == 2) begin
        check_eq("redir_fetch_req", s_req, 1);
        check_eq("redir_fetch_addr", s_addr, 32'h0040_0100);
      end
    end

    // Redirect in the same cycle as an accept
    mem_k = 2; mem_force = 1'b1; mem_force_data = 32'hCAFE_F00D;
    step(1, 0, 1, 32'h0040_1000);
    mem_force = 1'b0;
    check_eq("redir_acc_pc_next", s_pc_next, 32'h0040_1000);
    check_eq("redir_acc_pc_enable", s_pc_en, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check_eq("redir_acc_dropped", s_valid, 0);
    end
    check_eq("redir_acc_addr", s_addr, 32'h0040_1000);

    // Async reset pulse while in HOLD
    mem_k = 1;
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check_eq("hold_reached_no_req", s_req, 0);
    do_reset();
    step(0, 0, 0, 0);
    check_eq("hold_rst_valid", s_valid, 0);
    check_eq("hold_rst_req", s_req, 1);

    // Address wrap at the top of memory
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    check_eq("wrap_addr", s_addr, 32'hFFFF_FFFC);
    check_eq("wrap_pc_next", s_pc_next, 32'h0000_0000);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("wrap_ifid_pc", s_pc, 32'hFFFF_FFFC);
    check_eq("wrap_ifid_pc_plus4", s_plus4, 32'h0000_0000);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      mem_k = $urandom_range(1, 3);
      rr    = ($urandom_range(0, 9) < 7);
      rs    = ($urandom_range(0, 9) < 3);
      rd    = ($urandom_range(0, 19) == 0);
      tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      step(rr, rs, rd, tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
